// File: rtl/sw_result_collector.sv
// Result collector behind the last Smith-Waterman PE: unbiases the high score, tags it with an ID and
// saturation flag, and buffers it in a show-ahead FIFO. Optional macro RESULT_THRESHOLD_EN adds a score threshold.
module sw_result_collector #(
    parameter int                      SCORE_WIDTH = 12,
    parameter logic [SCORE_WIDTH-1:0]  ZERO        = {1'b1, {(SCORE_WIDTH-1){1'b0}}},
    parameter int                      FIFO_DEPTH  = 4,
    parameter int                      ID_WIDTH    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   vld_in,
    input  logic [SCORE_WIDTH-1:0] high_in,
`ifdef RESULT_THRESHOLD_EN
    input  logic [SCORE_WIDTH-1:0] threshold,
`endif
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [SCORE_WIDTH-1:0] res_score,
    output logic [ID_WIDTH-1:0]    res_id,
    output logic                   res_sat,
    output logic                   fifo_full,
    output logic [7:0]             drop_cnt
);

    localparam int               PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [SCORE_WIDTH-1:0] score;
        logic [ID_WIDTH-1:0]    id;
        logic                   sat;
    } entry_t;

    entry_t             mem_q [FIFO_DEPTH];
    entry_t             head_q, head_d;
    entry_t             cap;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ID_WIDTH-1:0] next_id_q, next_id_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;
    logic               valid_q, valid_d;
    logic               full_q, full_d;
    logic               keep, push, pop, drop;

    // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latches).
    always_comb begin
        cap.score = (high_in >= ZERO) ? high_in - ZERO : '0;
        cap.sat   = &high_in;
        cap.id    = next_id_q;

`ifdef RESULT_THRESHOLD_EN
        keep = cap.sat || (cap.score >= threshold);
`else
        keep = 1'b1;
`endif

        pop  = (count_q != '0) && res_ready;
        push = vld_in && keep && ((count_q != DEPTH_C) || pop);
        drop = vld_in && keep && !push;

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        next_id_d  = vld_in ? next_id_q + ID_WIDTH'(1) : next_id_q;
        drop_cnt_d = (drop && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;

        // The next head may be the entry being written this cycle (empty FIFO, or one entry popped and replaced).
        head_d = head_q;
        if (count_d != '0) begin
            head_d = (push && (wr_ptr_q == rd_ptr_d)) ? cap : mem_q[rd_ptr_d];
        end

        valid_d = (count_d != '0);
        full_d  = (count_d == DEPTH_C);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            next_id_q  <= '0;
            drop_cnt_q <= '0;
            head_q     <= '0;
            valid_q    <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            next_id_q  <= next_id_d;
            drop_cnt_q <= drop_cnt_d;
            head_q     <= head_d;
            valid_q    <= valid_d;
            full_q     <= full_d;
        end
    end

    // NOTE: storage is not reset; an entry is only read after it has been written, and outputs come from head_q.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= cap;
        end
    end

    assign res_valid = valid_q;
    assign res_score = head_q.score;
    assign res_id    = head_q.id;
    assign res_sat   = head_q.sat;
    assign fifo_full = full_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
